spi_slave_port: RTL
===================

Name: spi_slave_port

Overview:
- SPI slave (responder) for the SOPC: the far end of our SPI master links, so the FPGA can be clocked by an external SPI master.
- Mode 0 only (CPOL=0, CPHA=0), MSB first, fixed word size.
- Oversamples SCLK/SS_n/MOSI in the clk domain through synchronisers.
- CPU-side register port with RX/TX holding registers, sticky error flags and a maskable irq.

Parameters:
DATABITS, 16, SPI word width and CPU data width
SYNC_STAGES, 2, flip-flop depth of the SCLK/SS_n/MOSI synchronisers (≥2)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
SCLK  in  1  SPI clock from external master (async)
SS_n  in  1  slave select, active low (async)
MOSI  in  1  master-out data (async)
MISO  out  1  slave-out data = shift_reg[DATABITS-1]
MISO_oe  out  1  tristate enable; 1 while synchronised SS_n is low
spi_select  in  1  register-port chip select
mem_addr  in  3  register address
read_n  in  1  read strobe, active low
write_n  in  1  write strobe, active low
data_from_cpu  in  DATABITS  write data
data_to_cpu  out  DATABITS  read data, registered, valid 1 cycle after read
irq  out  1  registered interrupt
dataavailable  out  1  = RRDY
readyfordata  out  1  = TRDY

Behaviour:
- Reset (sync, high):
  - Registers/flags 0, except TRDY=1 (tx holding empty).
  - MISO=0, MISO_oe=0, irq=0, data_to_cpu=0, bit counter 0.
  - Reset mid-frame aborts the frame without setting ABRT.
- Register map:
  - 0 rxdata (r): read clears RRDY.
  - 1 txdata (w): write accepted only if TRDY=1 (sets primed, TRDY=0); otherwise ignored and TOE set.
  - 2 status (r; any write clears ROE, TOE, TUR, ABRT).
  - 3 control (r/w): irq enables, same bit positions as status.
  - Other addresses read 0 and ignore writes.
- Status bits:
  - 3 ROE; 4 TOE; 5 TUR; 6 TRDY; 7 RRDY.
  - 8 E = ROE|TOE|TUR|ABRT; 9 ABRT; 10 BUSY (SS active).
- Register access timing:
  - Access cycle = spi_select & ~read_n (or ~write_n); a held strobe acts once (edge-detected like the master port).
- irq timing:
  - irq registered: irq = |(status[9:3] & control[9:3]), one cycle after the status change.
- Input synchronisation:
  - Inputs pass SYNC_STAGES flops, then one history flop for edge detection.
  - SCLK high and low times must each be ≥ SYNC_STAGES+2 clk cycles.
- IDLE state (SS_n high):
  - Bit counter 0, MISO_oe 0.
- Frame start (synchronised SS_n falling edge):
  - If primed: shift_reg ← tx_holding, primed ← 0, TRDY ← 1.
  - Else: shift_reg ← 0 and TUR ← 1.
  - Enter SHIFT.
- SHIFT state:
  - SCLK rise: sample MOSI into rx_shift LSB, bit counter +1.
  - SCLK fall: shift_reg left by 1 (MSB out on MISO).
  - On the DATABITS-th rise: rx_holding ← completed word, RRDY ← 1 (ROE ← 1 if RRDY already 1; old data overwritten); counter ← 0.
  - The following SCLK fall reloads shift_reg from tx_holding (same primed/TUR rule) instead of shifting, so back-to-back words need no SS toggle.
- SS_n rises with counter ≠ 0:
  - Partial word discarded, ABRT ← 1, return to IDLE.
  - SS rise with counter = 0 is a clean end.
- Simultaneous events:
  - Word completion and CPU rxdata read in the same cycle: RRDY stays 1, no ROE, read returns the old word.
  - TX load at frame/word start and CPU txdata write in the same cycle: the load takes the old primed value; the write is judged against TRDY before the load (rejected with TOE if primed was 1).
  - Status write and flag set in the same cycle: the set wins.

Test Plan:
- tx=0xA5C3 primed; master sends 0x1234, SCLK period 16 clk → MISO bits = 0xA5C3 MSB first; rxdata=0x1234; RRDY=1; TRDY=1 after frame start.
- Two words under one SS (0x0001 then 0x8000), only the first tx primed (0xFFFF), second tx loaded between words (0x0F0F) → MISO 0xFFFF,0x0F0F; second RX without reading the first → ROE=1, rxdata=0x8000.
- Frame with nothing primed → MISO all zeros, TUR=1; with control bit5=1, irq rises 1 cycle after TUR.
- SS_n deasserted after 7 bits → ABRT=1, RRDY unchanged, next full frame receives correctly; status write clears ABRT.
- txdata written twice with no frame → second write ignored, TOE=1, tx_holding keeps the first value.
- Reset asserted for 1 cycle mid-frame (bit 9) → all status 0, TRDY=1, MISO_oe=0 until next SS fall, no ABRT.

Source files
------------

// File: rtl/spi_slave_port_if.sv
// rtl/spi_slave_port_if.sv - CPU register port bundle for the SPI slave
`timescale 1ns/1ps
interface spi_slave_port_if #(
    parameter int DATABITS = 16
);
    logic                spi_select;
    logic [2:0]          mem_addr;
    logic                read_n;
    logic                write_n;
    logic [DATABITS-1:0] data_from_cpu;
    logic [DATABITS-1:0] data_to_cpu;
    logic                irq;
    logic                dataavailable;
    logic                readyfordata;

    modport master (
        output spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  data_to_cpu, irq, dataavailable, readyfordata
    );

    modport slave (
        input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output data_to_cpu, irq, dataavailable, readyfordata
    );
endinterface

// File: rtl/spi_slave_port.sv
// rtl/spi_slave_port.sv - mode-0 SPI slave with oversampled pins and CPU register port
`timescale 1ns/1ps
module spi_slave_port #(
    parameter int DATABITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SCLK,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    spi_slave_port_if.slave   bus
);
    localparam int CW = $clog2(DATABITS + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam logic [2:0] A_RXDATA  = 3'd0;
    localparam logic [2:0] A_TXDATA  = 3'd1;
    localparam logic [2:0] A_STATUS  = 3'd2;
    localparam logic [2:0] A_CONTROL = 3'd3;

    // Synchroniser and history flops carry no reset so a mid-frame reset
    // sees SS_n already low and does not invent a frame start.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   ss_hist_q, ss_hist_d;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
        ss_hist_d   = ss_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        sclk_sync_q <= sclk_sync_d;
        ss_sync_q   <= ss_sync_d;
        mosi_sync_q <= mosi_sync_d;
        sclk_hist_q <= sclk_hist_d;
        ss_hist_q   <= ss_hist_d;
    end

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign ss_fall   = ~ss_s & ss_hist_q;
    assign ss_rise   = ss_s & ~ss_hist_q;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  reload_q, reload_d;
    logic [DATABITS-1:0]   shift_q, shift_d;
    logic [DATABITS-1:0]   rx_shift_q, rx_shift_d;
    logic [DATABITS-1:0]   rx_hold_q, rx_hold_d;
    logic [DATABITS-1:0]   tx_hold_q, tx_hold_d;
    logic [DATABITS-1:0]   control_q, control_d;
    logic [DATABITS-1:0]   data_to_cpu_q, data_to_cpu_d;
    logic                  primed_q, primed_d;
    logic                  rrdy_q, rrdy_d;
    logic                  roe_q, roe_d;
    logic                  toe_q, toe_d;
    logic                  tur_q, tur_d;
    logic                  abrt_q, abrt_d;
    logic                  irq_q, irq_d;
    logic                  rd_prev_q, rd_prev_d;
    logic                  wr_prev_q, wr_prev_d;

    logic                  rd_act, wr_act, rd_pulse, wr_pulse;
    logic                  rx_read, tx_write, st_write, ctl_write;
    logic                  tx_load;
    logic [DATABITS-1:0]   status_w;
    logic [DATABITS-1:0]   rx_next;

    assign rd_act    = bus.spi_select & ~bus.read_n;
    assign wr_act    = bus.spi_select & ~bus.write_n;
    assign rd_pulse  = rd_act & ~rd_prev_q;
    assign wr_pulse  = wr_act & ~wr_prev_q;
    assign rx_read   = rd_pulse & (bus.mem_addr == A_RXDATA);
    assign tx_write  = wr_pulse & (bus.mem_addr == A_TXDATA);
    assign st_write  = wr_pulse & (bus.mem_addr == A_STATUS);
    assign ctl_write = wr_pulse & (bus.mem_addr == A_CONTROL);
    assign rx_next   = {rx_shift_q[DATABITS-2:0], mosi_s};

    always_comb begin
        status_w     = '0;
        status_w[3]  = roe_q;
        status_w[4]  = toe_q;
        status_w[5]  = tur_q;
        status_w[6]  = ~primed_q;
        status_w[7]  = rrdy_q;
        status_w[8]  = roe_q | toe_q | tur_q | abrt_q;
        status_w[9]  = abrt_q;
        status_w[10] = (state_q == S_SHIFT);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        reload_d      = reload_q;
        shift_d       = shift_q;
        rx_shift_d    = rx_shift_q;
        rx_hold_d     = rx_hold_q;
        tx_hold_d     = tx_hold_q;
        control_d     = control_q;
        data_to_cpu_d = data_to_cpu_q;
        primed_d      = primed_q;
        rrdy_d        = rrdy_q;
        roe_d         = roe_q;
        toe_d         = toe_q;
        tur_d         = tur_q;
        abrt_d        = abrt_q;
        rd_prev_d     = rd_act;
        wr_prev_d     = wr_act;
        tx_load       = 1'b0;
        irq_d         = |(status_w[9:3] & control_q[9:3]);

        // CPU-side clears first so that same-cycle flag sets below win.
        if (rx_read) rrdy_d = 1'b0;
        if (st_write) begin
            roe_d  = 1'b0;
            toe_d  = 1'b0;
            tur_d  = 1'b0;
            abrt_d = 1'b0;
        end
        if (ctl_write) control_d = bus.data_from_cpu;
        if (rd_pulse) begin
            case (bus.mem_addr)
                A_RXDATA:  data_to_cpu_d = rx_hold_q;
                A_STATUS:  data_to_cpu_d = status_w;
                A_CONTROL: data_to_cpu_d = control_q;
                default:   data_to_cpu_d = '0;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                reload_d = 1'b0;
                if (ss_fall) begin
                    tx_load = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (ss_rise) begin
                    if (cnt_q != '0) abrt_d = 1'b1;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (cnt_q == CW'(DATABITS - 1)) begin
                        rx_hold_d = rx_next;
                        rrdy_d    = 1'b1;
                        if (rrdy_q && !rx_read) roe_d = 1'b1;
                        cnt_d     = '0;
                        reload_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        tx_load  = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        shift_d = {shift_q[DATABITS-2:0], 1'b0};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The load sees the old primed flag; a same-cycle txdata write is
        // judged against TRDY as it stood before the load.
        if (tx_load) begin
            if (primed_q) begin
                shift_d  = tx_hold_q;
                primed_d = 1'b0;
            end else begin
                shift_d = '0;
                tur_d   = 1'b1;
            end
        end
        if (tx_write) begin
            if (!primed_q) begin
                tx_hold_d = bus.data_from_cpu;
                primed_d  = 1'b1;
            end else begin
                toe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            reload_q      <= 1'b0;
            shift_q       <= '0;
            rx_shift_q    <= '0;
            rx_hold_q     <= '0;
            tx_hold_q     <= '0;
            control_q     <= '0;
            data_to_cpu_q <= '0;
            primed_q      <= 1'b0;
            rrdy_q        <= 1'b0;
            roe_q         <= 1'b0;
            toe_q         <= 1'b0;
            tur_q         <= 1'b0;
            abrt_q        <= 1'b0;
            irq_q         <= 1'b0;
            rd_prev_q     <= 1'b0;
            wr_prev_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reload_q      <= reload_d;
            shift_q       <= shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_hold_q     <= rx_hold_d;
            tx_hold_q     <= tx_hold_d;
            control_q     <= control_d;
            data_to_cpu_q <= data_to_cpu_d;
            primed_q      <= primed_d;
            rrdy_q        <= rrdy_d;
            roe_q         <= roe_d;
            toe_q         <= toe_d;
            tur_q         <= tur_d;
            abrt_q        <= abrt_d;
            irq_q         <= irq_d;
            rd_prev_q     <= rd_prev_d;
            wr_prev_q     <= wr_prev_d;
        end
    end

    assign MISO              = shift_q[DATABITS-1];
    assign MISO_oe           = (state_q == S_SHIFT);
    assign bus.data_to_cpu   = data_to_cpu_q;
    assign bus.irq           = irq_q;
    assign bus.dataavailable = rrdy_q;
    assign bus.readyfordata  = ~primed_q;
endmodule
